// File: rtl/slot_alloc_sched.sv
`default_nettype none
// ============================================================================
// Module   : slot_alloc_sched
// Brief    : 16-slot tag allocator; lowest free slot granted one cycle after request.
// Revision : 1.0 - initial release
// ============================================================================
module slot_alloc_sched #(
    parameter int NUM_SLOTS = 16,
    parameter int ID_W      = 4,
    parameter int CNT_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alloc_req,
    output logic                 alloc_gnt,
    output logic [ID_W-1:0]      alloc_id,
    output logic                 alloc_nack,
    input  logic                 free_vld,
    input  logic [ID_W-1:0]      free_id,
    input  logic                 flush,
    output logic [NUM_SLOTS-1:0] busy_mask,
    output logic [CNT_W-1:0]     used_cnt,
    output logic                 full,
    output logic                 empty,
    output logic                 err_dbl_free
);

    localparam logic [ID_W:0]  C_ENC_NONE = (ID_W+1)'(NUM_SLOTS);
    localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(NUM_SLOTS);

    logic [NUM_SLOTS-1:0] r_busy;
    logic [CNT_W-1:0]     r_used_cnt;
    logic                 r_full;
    logic                 r_empty;
    logic                 r_gnt;
    logic                 r_nack;
    logic [ID_W-1:0]      r_id;
    logic                 r_dbl;

    logic [ID_W:0]        w_enc;
    logic                 w_none_free;
    logic                 w_grant;
    logic                 w_nack;
    logic                 w_free_hit;
    logic                 w_free_ok;
    logic                 w_dbl;
    logic [NUM_SLOTS-1:0] w_gnt_onehot;
    logic [NUM_SLOTS-1:0] w_free_onehot;
    logic [NUM_SLOTS-1:0] w_busy_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;

    // Zero-priority encoder over the registered mask: lowest clear bit wins.
    always_comb begin
        w_enc = C_ENC_NONE;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_enc = (ID_W+1)'(i);
            end
        end
    end

    assign w_none_free = (w_enc == C_ENC_NONE);
    assign w_free_hit  = r_busy[free_id];

    // Flush swallows any request or release presented alongside it.
    assign w_grant   = alloc_req && !flush && !w_none_free;
    assign w_nack    = alloc_req && !flush &&  w_none_free;
    assign w_free_ok = free_vld  && !flush &&  w_free_hit;
    assign w_dbl     = free_vld  && !flush && !w_free_hit;

    generate
        for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_onehot
            assign w_gnt_onehot[g]  = w_grant   && (w_enc[ID_W-1:0] == ID_W'(g));
            assign w_free_onehot[g] = w_free_ok && (free_id == ID_W'(g));
        end
    endgenerate

    // Granted slot is free and freed slot is busy, so the two never collide.
    always_comb begin
        w_busy_nxt = r_busy;
        if (flush) begin
            w_busy_nxt = '0;
        end else begin
            w_busy_nxt = (r_busy | w_gnt_onehot) & ~w_free_onehot;
        end
    end

    always_comb begin
        w_cnt_nxt = r_used_cnt;
        if (flush) begin
            w_cnt_nxt = '0;
        end else if (w_grant && !w_free_ok) begin
            w_cnt_nxt = r_used_cnt + CNT_W'(1);
        end else if (!w_grant && w_free_ok) begin
            w_cnt_nxt = r_used_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy     <= '0;
            r_used_cnt <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_gnt      <= 1'b0;
            r_nack     <= 1'b0;
            r_id       <= '0;
            r_dbl      <= 1'b0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_used_cnt <= w_cnt_nxt;
            r_full     <= (w_cnt_nxt == C_CNT_FULL);
            r_empty    <= (w_cnt_nxt == '0);
            r_gnt      <= w_grant;
            r_nack     <= w_nack;
            r_dbl      <= w_dbl;
            if (w_grant) begin
                r_id <= w_enc[ID_W-1:0];
            end
        end
    end

    assign busy_mask    = r_busy;
    assign used_cnt     = r_used_cnt;
    assign full         = r_full;
    assign empty        = r_empty;
    assign alloc_gnt    = r_gnt;
    assign alloc_nack   = r_nack;
    assign alloc_id     = r_id;
    assign err_dbl_free = r_dbl;

endmodule
`default_nettype wire

// File: tb/tb_slot_alloc_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_slot_alloc_sched
// Brief    : Directed vector bench for slot_alloc_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_slot_alloc_sched;

    logic        clk;
    logic        rst_n;
    logic        alloc_req;
    logic        alloc_gnt;
    logic [3:0]  alloc_id;
    logic        alloc_nack;
    logic        free_vld;
    logic [3:0]  free_id;
    logic        flush;
    logic [15:0] busy_mask;
    logic [4:0]  used_cnt;
    logic        full;
    logic        empty;
    logic        err_dbl_free;

    int checks;
    int errors;

    typedef struct {
        logic        rst_n;
        logic        req;
        logic        fv;
        logic [3:0]  fid;
        logic        flush;
        logic        gnt;
        logic        nack;
        logic [3:0]  id;
        logic        dbl;
        logic [15:0] mask;
        logic [4:0]  cnt;
        logic        full;
        logic        empty;
    } vec_t;

    vec_t vecs[$];

    slot_alloc_sched #(
        .NUM_SLOTS (16),
        .ID_W      (4),
        .CNT_W     (5)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alloc_req    (alloc_req),
        .alloc_gnt    (alloc_gnt),
        .alloc_id     (alloc_id),
        .alloc_nack   (alloc_nack),
        .free_vld     (free_vld),
        .free_id      (free_id),
        .flush        (flush),
        .busy_mask    (busy_mask),
        .used_cnt     (used_cnt),
        .full         (full),
        .empty        (empty),
        .err_dbl_free (err_dbl_free)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int step);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL step %0d %s: got 0x%0h expected 0x%0h", step, name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic q, input logic fv, input logic [3:0] fid,
                       input logic fl, input logic g, input logic n, input logic [3:0] id,
                       input logic d, input logic [15:0] m, input logic [4:0] c,
                       input logic fu, input logic em);
        vec_t v;
        v.rst_n = r;  v.req = q;   v.fv = fv;  v.fid = fid; v.flush = fl;
        v.gnt = g;    v.nack = n;  v.id = id;  v.dbl = d;   v.mask = m;
        v.cnt = c;    v.full = fu; v.empty = em;
        vecs.push_back(v);
    endtask

    // Drive on the falling edge, let the rising edge act, sample 1 ns later.
    task automatic apply_check(input vec_t v, input int step);
        @(negedge clk);
        rst_n     = v.rst_n;
        alloc_req = v.req;
        free_vld  = v.fv;
        free_id   = v.fid;
        flush     = v.flush;
        @(posedge clk);
        #1;
        chk("alloc_gnt",    32'(alloc_gnt),    32'(v.gnt),   step);
        chk("alloc_nack",   32'(alloc_nack),   32'(v.nack),  step);
        chk("alloc_id",     32'(alloc_id),     32'(v.id),    step);
        chk("err_dbl_free", 32'(err_dbl_free), 32'(v.dbl),   step);
        chk("busy_mask",    32'(busy_mask),    32'(v.mask),  step);
        chk("used_cnt",     32'(used_cnt),     32'(v.cnt),   step);
        chk("full",         32'(full),         32'(v.full),  step);
        chk("empty",        32'(empty),        32'(v.empty), step);
    endtask

    initial begin
        vec_t v;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        alloc_req = 1'b0;
        free_vld  = 1'b0;
        free_id   = 4'd0;
        flush     = 1'b0;

        // Reset state after two reset edges.
        v = '{rst_n:1'b0, req:1'b0, fv:1'b0, fid:4'd0, flush:1'b0, gnt:1'b0, nack:1'b0,
              id:4'd0, dbl:1'b0, mask:16'h0000, cnt:5'd0, full:1'b0, empty:1'b1};
        apply_check(v, 0);
        apply_check(v, 1);

        // Fill the pool: ids 0..15 on consecutive cycles.
        for (int i = 0; i < 16; i++) begin
            v = '{rst_n:1'b1, req:1'b1, fv:1'b0, fid:4'd0, flush:1'b0, gnt:1'b1, nack:1'b0,
                  id:4'(i), dbl:1'b0, mask:16'((32'd2 << i) - 32'd1), cnt:5'(i + 1),
                  full:(i == 15), empty:1'b0};
            apply_check(v, 100 + i);
        end

        //   rst q fv fid fl | g n id d mask      cnt fu em
        add(1, 1, 0, 0, 0,   0, 1, 15, 0, 16'hFFFF, 16, 1, 0);  // nack when full
        add(1, 0, 0, 0, 0,   0, 0, 15, 0, 16'hFFFF, 16, 1, 0);  // nack is a pulse
        add(1, 0, 1, 5, 0,   0, 0, 15, 0, 16'hFFDF, 15, 0, 0);
        add(1, 1, 0, 0, 0,   1, 0,  5, 0, 16'hFFFF, 16, 1, 0);  // refill slot 5
        add(1, 1, 1, 3, 0,   0, 1,  5, 0, 16'hFFF7, 15, 0, 0);  // free does not rescue
        add(1, 1, 1, 7, 1,   0, 0,  5, 0, 16'h0000,  0, 0, 1);  // flush ignores req/free
        add(1, 0, 1, 9, 0,   0, 0,  5, 1, 16'h0000,  0, 0, 1);  // double free
        add(1, 0, 0, 0, 0,   0, 0,  5, 0, 16'h0000,  0, 0, 1);
        add(1, 1, 0, 0, 0,   1, 0,  0, 0, 16'h0001,  1, 0, 0);
        add(1, 1, 0, 0, 0,   1, 0,  1, 0, 16'h0003,  2, 0, 0);
        add(1, 1, 0, 0, 0,   1, 0,  2, 0, 16'h0007,  3, 0, 0);
        add(1, 1, 0, 0, 0,   1, 0,  3, 0, 16'h000F,  4, 0, 0);
        add(1, 1, 1, 1, 0,   1, 0,  4, 0, 16'h001D,  4, 0, 0);  // freed slot not reused
        add(1, 1, 0, 0, 0,   1, 0,  1, 0, 16'h001F,  5, 0, 0);
        add(1, 1, 0, 0, 0,   1, 0,  5, 0, 16'h003F,  6, 0, 0);
        add(1, 1, 0, 0, 0,   1, 0,  6, 0, 16'h007F,  7, 0, 0);
        add(1, 1, 0, 0, 0,   1, 0,  7, 0, 16'h00FF,  8, 0, 0);
        add(1, 1, 0, 2, 1,   0, 0,  7, 0, 16'h0000,  0, 0, 1);  // flush + req
        add(1, 1, 0, 0, 0,   1, 0,  0, 0, 16'h0001,  1, 0, 0);
        add(1, 1, 0, 0, 0,   1, 0,  1, 0, 16'h0003,  2, 0, 0);
        add(1, 1, 0, 0, 0,   1, 0,  2, 0, 16'h0007,  3, 0, 0);
        add(1, 1, 0, 0, 0,   1, 0,  3, 0, 16'h000F,  4, 0, 0);
        add(1, 1, 0, 0, 0,   1, 0,  4, 0, 16'h001F,  5, 0, 0);
        add(1, 1, 0, 0, 0,   1, 0,  5, 0, 16'h003F,  6, 0, 0);
        add(1, 1, 0, 0, 0,   1, 0,  6, 0, 16'h007F,  7, 0, 0);
        add(1, 1, 0, 0, 0,   1, 0,  7, 0, 16'h00FF,  8, 0, 0);
        add(1, 1, 0, 0, 0,   1, 0,  8, 0, 16'h01FF,  9, 0, 0);
        add(1, 1, 0, 0, 0,   1, 0,  9, 0, 16'h03FF, 10, 0, 0);
        add(1, 1, 0, 0, 0,   1, 0, 10, 0, 16'h07FF, 11, 0, 0);
        add(1, 1, 0, 0, 0,   1, 0, 11, 0, 16'h0FFF, 12, 0, 0);
        add(1, 0, 1, 4, 0,   0, 0, 11, 0, 16'h0FEF, 11, 0, 0);
        add(1, 0, 1, 5, 0,   0, 0, 11, 0, 16'h0FCF, 10, 0, 0);
        add(1, 0, 1, 6, 0,   0, 0, 11, 0, 16'h0F8F,  9, 0, 0);
        add(1, 0, 1, 7, 0,   0, 0, 11, 0, 16'h0F0F,  8, 0, 0);
        add(0, 1, 0, 0, 0,   0, 0,  0, 0, 16'h0000,  0, 0, 1);  // reset beats request
        add(1, 1, 0, 0, 0,   1, 0,  0, 0, 16'h0001,  1, 0, 0);
        add(1, 1, 0, 0, 0,   1, 0,  1, 0, 16'h0003,  2, 0, 0);

        foreach (vecs[k]) begin
            apply_check(vecs[k], 200 + k);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/slot_alloc_sched.md
Name: slot_alloc_sched

Overview:
Tag/slot allocator that shares a pool of 16 execution slots between SPU issue requests. It keeps a 16-bit busy mask and finds the lowest-index free slot with the zero-priority encoder (16-bit in, 5-bit out, value 16 = no zero found). It returns registered grants with slot IDs and accepts slot releases from the completion path. It sits between the issue stage and the slot-tracked functional units.

Parameters:
NUM_SLOTS, 16, number of slots; fixed at 16 to match the encoder width.
ID_W, 4, slot ID width.
CNT_W, 5, occupancy counter width; holds 0..16.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
alloc_req  in  1  request one slot this cycle
alloc_gnt  out  1  registered 1-cycle pulse: slot granted
alloc_id  out  ID_W  granted slot ID; valid when alloc_gnt=1, else holds last value
alloc_nack  out  1  registered 1-cycle pulse: request refused because pool full
free_vld  in  1  release slot free_id this cycle
free_id  in  ID_W  slot to release
flush  in  1  release all slots
busy_mask  out  NUM_SLOTS  current busy bits, bit i = slot i in use
used_cnt  out  CNT_W  number of busy slots
full  out  1  used_cnt==16 (registered)
empty  out  1  used_cnt==0 (registered)
err_dbl_free  out  1  registered 1-cycle pulse: free of a non-busy slot

Behaviour:
- Synchronous active-low reset. On rst_n=0 at a rising edge:
  - busy_mask=0, used_cnt=0.
  - alloc_gnt=0, alloc_nack=0, alloc_id=0, err_dbl_free=0.
  - full=0, empty=1.
  - Reset mid-operation discards all allocations; requests pending at that edge get no response.
- Search: encoder input is the current registered busy_mask. enc_out<16 gives the free slot; enc_out==16 means none free. Lowest index wins.
- Allocation (latency 1):
  - alloc_req=1 at edge N with a free slot s: at N+1 alloc_gnt=1, alloc_id=s, busy bit s set.
  - alloc_req=1 at edge N with no free slot: at N+1 alloc_nack=1, alloc_gnt=0, mask unchanged.
  - Requests are not queued. The requester re-asserts after a nack.
  - Back-to-back requests on consecutive cycles each get distinct slots.
- Release:
  - free_vld=1 with busy[free_id]=1: bit cleared at the next edge.
  - free_vld=1 with busy[free_id]=0: mask unchanged; err_dbl_free=1 for one cycle at the next edge.
- Simultaneous alloc_req and free_vld, same edge:
  - Search uses the pre-free mask, so the freed slot is not reusable in that cycle.
  - When full, a free in the same cycle does not rescue the request; the response is a nack and used_cnt becomes 15.
  - Otherwise the grant takes a different slot, the free slot clears, and used_cnt is unchanged.
- Flush:
  - flush=1 clears the entire mask and used_cnt at the next edge.
  - alloc_req and free_vld in the same cycle are ignored: no gnt, no nack, no err.
- Counter:
  - used_cnt += 1 on grant, −= 1 on valid free, net 0 when both occur.
  - Never wraps; invariant used_cnt == popcount(busy_mask).
  - full and empty are registered from the next-state count.
- alloc_gnt, alloc_nack and err_dbl_free are never high for more than one cycle per event. alloc_gnt and alloc_nack are mutually exclusive.

Test Plan:
- Reset then 16 consecutive alloc_req cycles → alloc_id 0,1,…,15 on successive cycles; after the last grant full=1, used_cnt=16, busy_mask=16'hFFFF.
- 17th alloc_req while full → alloc_nack=1 one cycle later, alloc_gnt=0, mask stays 16'hFFFF.
- From full: free_id=5, then alloc_req → slot 5 cleared (mask 16'hFFDF, used_cnt=15), then alloc_id=5, full=1 again.
- Full pool, same cycle alloc_req=1 + free_vld(free_id=3) → alloc_nack=1, mask 16'hFFF7, used_cnt=15. With mask 16'h000F, same cycle alloc_req + free_id=1 → alloc_id=4, mask 16'h001D, used_cnt=4.
- free_id=9 on an empty pool → err_dbl_free pulse, used_cnt stays 0, empty=1. Then flush with mask 16'h00FF plus alloc_req → mask 0, no gnt/nack, empty=1.
- Reset mid-operation: rst_n=0 for one edge with mask 16'h0F0F and alloc_req=1 → next cycle all outputs at reset values, no grant; first alloc afterwards returns id 0.
